// File: rtl/uart_port_if_if.sv
// uart_port_if_if
//   CPU-side byte bus between the SBC and the UART port front end.
//   master modport : CPU / bus side (drives address, strobes, write data)
//   slave  modport : uart_port_if (returns read data)
//   Signals:
//     addr     0 = data port, 1 = status/control port
//     rd_stb   read strobe, active high, may span several cycles
//     wr_stb   write strobe, active high, may span several cycles
//     wr_data  write data, valid while wr_stb is high
//     rd_data  read data, combinational on addr
interface uart_port_if_if;
   logic       addr;
   logic       rd_stb;
   logic       wr_stb;
   logic [7:0] wr_data;
   logic [7:0] rd_data;

   modport master (output addr, output rd_stb, output wr_stb, output wr_data, input rd_data);
   modport slave  (input addr, input rd_stb, input wr_stb, input wr_data, output rd_data);
endinterface

// File: rtl/uart_port_if.sv
// uart_port_if
//   CPU-side I/O front end for the UART core. Holds one received byte for the
//   CPU, buffers CPU writes in a small TX FIFO and launches them into the core
//   one at a time.
//   Optional feature macro: UART_PORT_IRQ_EN (receive interrupt on int_n and
//   writable rx_ie bit). When undefined, int_n is tied high and rx_ie reads 0.
//   Ports:
//     clk, rst_n            system clock, async active-low reset
//     bus                   CPU byte bus (slave modport of uart_port_if_if)
//     uart_rx_byte          received byte from the core
//     uart_received         one-cycle pulse, byte complete
//     uart_recv_error       one-cycle pulse, framing error
//     uart_data_read        one-cycle acknowledge back to the core
//     uart_tx_byte          byte presented to the core
//     uart_transmit         one-cycle transmit request
//     uart_is_transmitting  core TX busy flag
//     int_n                 active-low receive interrupt
module uart_port_if #(
   parameter int TX_DEPTH = 4,
   parameter int TX_AW    = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   uart_port_if_if.slave      bus,
   input  logic [7:0]         uart_rx_byte,
   input  logic               uart_received,
   input  logic               uart_recv_error,
   output logic               uart_data_read,
   output logic [7:0]         uart_tx_byte,
   output logic               uart_transmit,
   input  logic               uart_is_transmitting,
   output logic               int_n
);

   typedef enum logic [1:0] {
      T_IDLE      = 2'd0,
      T_WAIT_BUSY = 2'd1,
      T_WAIT_DONE = 2'd2
   } tx_state_t;

   localparam logic [TX_AW:0] FULL_CNT = (TX_AW + 1)'(TX_DEPTH);

   tx_state_t        state_r, state_s;
   logic [1:0]       wait_cnt_r, wait_cnt_s;
   logic             rd_stb_r, wr_stb_r;
   logic             wr_rise_s, rd_fall_s, data_wr_s, ctrl_wr_s, rx_pop_s, sticky_clr_s;
   logic             fifo_empty_s, fifo_full_s, launch_s, push_s, overflow_set_s, tx_busy_s;
   logic [7:0]       status_s;
   logic [7:0]       rx_data_r;
   logic             rx_avail_r, rx_overrun_r, rx_frame_err_r, tx_overflow_r, rx_ie_r;
   logic             data_read_r, transmit_r, int_n_r;
   logic [7:0]       tx_byte_r;
   logic [7:0]       mem_r [TX_DEPTH];
   logic [TX_AW-1:0] wr_ptr_r, rd_ptr_r;
   logic [TX_AW:0]   count_r;

   // Strobe edge decode and FIFO / sticky-flag control terms
   always_comb begin
      wr_rise_s      = bus.wr_stb & ~wr_stb_r;
      rd_fall_s      = rd_stb_r & ~bus.rd_stb;
      data_wr_s      = wr_rise_s & ~bus.addr;
      ctrl_wr_s      = wr_rise_s & bus.addr;
      rx_pop_s       = rd_fall_s & ~bus.addr;
      sticky_clr_s   = ctrl_wr_s & bus.wr_data[4];
      fifo_empty_s   = (count_r == {(TX_AW + 1){1'b0}});
      fifo_full_s    = (count_r == FULL_CNT);
      tx_busy_s      = ~fifo_empty_s | (state_r != T_IDLE);
   end

   // Push acceptance: a full FIFO still takes a byte when the head leaves this cycle
   always_comb begin
      push_s         = data_wr_s & (~fifo_full_s | launch_s);
      overflow_set_s = data_wr_s & fifo_full_s & ~launch_s;
   end

   // TX FSM next state and launch decision
   always_comb begin
      state_s    = state_r;
      wait_cnt_s = wait_cnt_r;
      launch_s   = 1'b0;
      case (state_r)
         T_IDLE: begin
            if (!fifo_empty_s && !uart_is_transmitting) begin
               launch_s   = 1'b1;
               wait_cnt_s = 2'd0;
               state_s    = T_WAIT_BUSY;
            end else begin
               state_s    = T_IDLE;
            end
         end
         T_WAIT_BUSY: begin
            // Give the core 4 cycles to report busy; otherwise the byte is lost
            if (uart_is_transmitting) begin
               state_s = T_WAIT_DONE;
            end else if (wait_cnt_r == 2'd3) begin
               state_s = T_IDLE;
            end else begin
               wait_cnt_s = wait_cnt_r + 2'd1;
            end
         end
         T_WAIT_DONE: begin
            if (!uart_is_transmitting) begin
               state_s = T_IDLE;
            end else begin
               state_s = T_WAIT_DONE;
            end
         end
         default: begin
            state_s = T_IDLE;
         end
      endcase
   end

   // Status byte and CPU read mux
   always_comb begin
      status_s = {tx_busy_s, rx_ie_r, fifo_empty_s, tx_overflow_r,
                  rx_frame_err_r, rx_overrun_r, ~fifo_full_s, rx_avail_r};
      if (bus.addr) begin
         bus.rd_data = status_s;
      end else if (rx_avail_r) begin
         bus.rd_data = rx_data_r;
      end else begin
         bus.rd_data = 8'h00;
      end
   end

   // Strobe history for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_stb_r <= 1'b0;
         wr_stb_r <= 1'b0;
      end else begin
         rd_stb_r <= bus.rd_stb;
         wr_stb_r <= bus.wr_stb;
      end
   end

   // RX holding register, acknowledge pulse and sticky flags (set wins over clear)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data_r      <= 8'h00;
         rx_avail_r     <= 1'b0;
         rx_overrun_r   <= 1'b0;
         rx_frame_err_r <= 1'b0;
         tx_overflow_r  <= 1'b0;
         data_read_r    <= 1'b0;
      end else begin
         if (uart_received) begin
            if (!rx_avail_r || rx_pop_s) begin
               rx_data_r <= uart_rx_byte;
            end
            rx_avail_r <= 1'b1;
         end else if (rx_pop_s) begin
            rx_avail_r <= 1'b0;
         end
         rx_overrun_r   <= (uart_received & rx_avail_r & ~rx_pop_s) | (rx_overrun_r & ~sticky_clr_s);
         rx_frame_err_r <= uart_recv_error | (rx_frame_err_r & ~sticky_clr_s);
         tx_overflow_r  <= overflow_set_s | (tx_overflow_r & ~sticky_clr_s);
         data_read_r    <= uart_received;
      end
   end

   // Interrupt enable and registered interrupt output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_ie_r <= 1'b0;
         int_n_r <= 1'b1;
      end else begin
`ifdef UART_PORT_IRQ_EN
         if (ctrl_wr_s) begin
            rx_ie_r <= bus.wr_data[0];
         end
         int_n_r <= ~(rx_ie_r & rx_avail_r);
`else
         rx_ie_r <= 1'b0;
         int_n_r <= 1'b1;
`endif
      end
   end

   // FIFO storage; contents are discarded on reset through the pointers
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= bus.wr_data;
      end
   end

   // FIFO pointers and occupancy count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {TX_AW{1'b0}};
         rd_ptr_r <= {TX_AW{1'b0}};
         count_r  <= {(TX_AW + 1){1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + TX_AW'(1);
         end
         if (launch_s) begin
            rd_ptr_r <= rd_ptr_r + TX_AW'(1);
         end
         case ({push_s, launch_s})
            2'b10:   count_r <= count_r + (TX_AW + 1)'(1);
            2'b01:   count_r <= count_r - (TX_AW + 1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // TX FSM state, timeout counter and launch outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= T_IDLE;
         wait_cnt_r <= 2'd0;
         transmit_r <= 1'b0;
         tx_byte_r  <= 8'h00;
      end else begin
         state_r    <= state_s;
         wait_cnt_r <= wait_cnt_s;
         transmit_r <= launch_s;
         if (launch_s) begin
            tx_byte_r <= mem_r[rd_ptr_r];
         end
      end
   end

   assign uart_data_read = data_read_r;
   assign uart_transmit  = transmit_r;
   assign uart_tx_byte   = tx_byte_r;
   assign int_n          = int_n_r;

endmodule

// File: tb/tb_uart_port_if.sv
// tb_uart_port_if
//   Directed bench for uart_port_if: reset state, RX holding/overrun/framing,
//   sticky clear, TX FIFO overflow and ordering, lost-byte timeout, interrupt.
module tb_uart_port_if;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] uart_rx_byte = 8'h00;
   logic       uart_received = 1'b0;
   logic       uart_recv_error = 1'b0;
   logic       uart_data_read;
   logic [7:0] uart_tx_byte;
   logic       uart_transmit;
   logic       uart_is_transmitting;
   logic       int_n;

   logic       force_busy = 1'b0;
   logic       core_ack = 1'b1;
   int         busy_cnt = 0;
   int         cyc_cnt = 0;
   logic [7:0] captured [$];
   int         cap_t [$];

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] rdv;
   logic [7:0] exp_ie_status;
   logic [7:0] exp_int_on;

   uart_port_if_if bus ();

   uart_port_if #(.TX_DEPTH(4), .TX_AW(2)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .bus                  (bus),
      .uart_rx_byte         (uart_rx_byte),
      .uart_received        (uart_received),
      .uart_recv_error      (uart_recv_error),
      .uart_data_read       (uart_data_read),
      .uart_tx_byte         (uart_tx_byte),
      .uart_transmit        (uart_transmit),
      .uart_is_transmitting (uart_is_transmitting),
      .int_n                (int_n)
   );

   always #5 clk = ~clk;

   // Core TX model: records launched bytes, optionally goes busy for 3 cycles
   always @(posedge clk) begin
      cyc_cnt <= cyc_cnt + 1;
      if (uart_transmit) begin
         captured.push_back(uart_tx_byte);
         cap_t.push_back(cyc_cnt);
         if (core_ack) busy_cnt <= 3;
      end else if (busy_cnt != 0) begin
         busy_cnt <= busy_cnt - 1;
      end
   end

   assign uart_is_transmitting = force_busy | (busy_cnt != 0);

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
      end
   endtask

   task automatic status(input string tag, input logic [7:0] exp);
      bus.addr = 1'b1;
      #1;
      check(tag, bus.rd_data, exp);
   endtask

   task automatic cpu_write(input logic a, input logic [7:0] d);
      bus.addr = a;
      bus.wr_data = d;
      bus.wr_stb = 1'b1;
      cyc(1);
      bus.wr_stb = 1'b0;
      cyc(1);
   endtask

   task automatic cpu_read(output logic [7:0] d);
      bus.addr = 1'b0;
      bus.rd_stb = 1'b1;
      cyc(1);
      d = bus.rd_data;
      bus.rd_stb = 1'b0;
      cyc(1);
   endtask

   task automatic rx_pulse(input logic [7:0] b);
      uart_rx_byte = b;
      uart_received = 1'b1;
      cyc(1);
      uart_received = 1'b0;
   endtask

   initial begin
`ifdef UART_PORT_IRQ_EN
      exp_ie_status = 8'h62;
      exp_int_on    = 8'h00;
`else
      exp_ie_status = 8'h22;
      exp_int_on    = 8'h01;
`endif
      bus.addr = 1'b0;
      bus.rd_stb = 1'b0;
      bus.wr_stb = 1'b0;
      bus.wr_data = 8'h00;
      cyc(3);
      rst_n = 1'b1;
      cyc(1);

      // Reset state
      status("rst_status", 8'h22);
      bus.addr = 1'b0;
      #1;
      check("rst_data", bus.rd_data, 8'h00);
      check("rst_int_n", {7'd0, int_n}, 8'h01);
      check("rst_transmit", {7'd0, uart_transmit}, 8'h00);
      check("rst_data_read", {7'd0, uart_data_read}, 8'h00);
      check("rst_tx_byte", uart_tx_byte, 8'h00);

      // Single receive, long read
      rx_pulse(8'hA5);
      check("ack_hi", {7'd0, uart_data_read}, 8'h01);
      cyc(1);
      check("ack_lo", {7'd0, uart_data_read}, 8'h00);
      status("rx_avail", 8'h23);
      bus.addr = 1'b0;
      bus.rd_stb = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         check("long_read", bus.rd_data, 8'hA5);
      end
      bus.rd_stb = 1'b0;
      cyc(1);
      status("rx_popped", 8'h22);
      check("int_n_noie", {7'd0, int_n}, 8'h01);

      // Overrun keeps the first byte
      rx_pulse(8'h11);
      cyc(1);
      rx_pulse(8'h22);
      cyc(1);
      bus.addr = 1'b0;
      #1;
      check("ovr_data", bus.rd_data, 8'h11);
      status("ovr_status", 8'h27);
      cpu_write(1'b1, 8'h10);
      status("ovr_cleared", 8'h23);
      cpu_read(rdv);
      check("ovr_read", rdv, 8'h11);
      status("ovr_empty", 8'h22);

      // Framing error, set wins over a same-cycle clear
      uart_recv_error = 1'b1;
      cyc(1);
      uart_recv_error = 1'b0;
      status("ferr_set", 8'h2A);
      bus.addr = 1'b1;
      bus.wr_data = 8'h10;
      bus.wr_stb = 1'b1;
      uart_recv_error = 1'b1;
      cyc(1);
      bus.wr_stb = 1'b0;
      uart_recv_error = 1'b0;
      cyc(1);
      status("ferr_set_wins", 8'h2A);
      cpu_write(1'b1, 8'h10);
      status("ferr_cleared", 8'h22);

      // Pop and receive in the same cycle
      rx_pulse(8'h33);
      cyc(1);
      bus.addr = 1'b0;
      bus.rd_stb = 1'b1;
      cyc(1);
      bus.rd_stb = 1'b0;
      uart_rx_byte = 8'h44;
      uart_received = 1'b1;
      cyc(1);
      uart_received = 1'b0;
      check("pop_rx_data", bus.rd_data, 8'h44);
      status("pop_rx_status", 8'h23);
      cpu_read(rdv);
      status("pop_rx_empty", 8'h22);

      // TX FIFO fill while core busy, overflow, in-order delivery
      captured.delete();
      cap_t.delete();
      force_busy = 1'b1;
      core_ack = 1'b1;
      for (int i = 0; i < 5; i++) cpu_write(1'b0, 8'h41 + 8'(i));
      status("fifo_full", 8'h90);
      force_busy = 1'b0;
      for (int i = 0; i < 200 && captured.size() < 4; i++) cyc(1);
      check("tx_count", 8'(captured.size()), 8'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < captured.size()) check("tx_order", captured[i], 8'h41 + 8'(i));
      end
      cyc(10);
      check("tx_extra", 8'(captured.size()), 8'd4);
      status("tx_drained", 8'h32);
      cpu_write(1'b1, 8'h10);
      status("tx_ovf_clr", 8'h22);

      // Core never goes busy: timeout then next launch
      captured.delete();
      cap_t.delete();
      core_ack = 1'b0;
      cpu_write(1'b0, 8'h61);
      cpu_write(1'b0, 8'h62);
      for (int i = 0; i < 100 && captured.size() < 2; i++) cyc(1);
      check("to_count", 8'(captured.size()), 8'd2);
      if (captured.size() == 2) begin
         check("to_byte0", captured[0], 8'h61);
         check("to_byte1", captured[1], 8'h62);
         check("to_gap", 8'(cap_t[1] - cap_t[0]), 8'd5);
      end
      cyc(10);
      status("to_idle", 8'h22);
      core_ack = 1'b1;

      // Receive interrupt
      cpu_write(1'b1, 8'h01);
      status("ie_status", exp_ie_status);
      rx_pulse(8'h5A);
      cyc(1);
      check("irq_on", {7'd0, int_n}, exp_int_on);
      cpu_read(rdv);
      check("irq_data", rdv, 8'h5A);
      cyc(1);
      check("irq_off", {7'd0, int_n}, 8'h01);
      status("irq_final", exp_ie_status);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
